// File: rtl/siso_shift_ctrl.sv
// Sequencer for a serial-in/serial-out shift register chain: shifts a word
// through the chain LSB-first, reassembles it from the chain output and flags loopback mismatch.
module siso_shift_ctrl #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             hold,
  output logic             sr_s_in,
  output logic             sr_load,
  input  logic             sr_s_out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             mismatch,
  output logic             busy
);

  localparam int            CW   = $clog2(WIDTH + DEPTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH + DEPTH - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state, state_next;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] tx, rx, rx_next;
  logic             step, finish;

  always_comb begin
    // NOTE: every variable written here gets a default first so no latch is inferred.
    state_next = state;
    rx_next    = rx;
    sr_s_in    = 1'b0;
    step       = (state == SHIFT) && !hold;
    finish     = step && (cnt == LAST);
    // Drive tx[cnt] while cnt < WIDTH (zeros flush the rest); capture bit cnt-DEPTH from the tail.
    for (int i = 0; i < WIDTH; i++) begin
      if ((state == SHIFT) && (cnt == CW'(i)))
        sr_s_in = tx[i];
      if (step && (cnt == CW'(i + DEPTH)))
        rx_next[i] = sr_s_out;
    end
    case (state)
      IDLE:    if (in_valid)  state_next = SHIFT;
      SHIFT:   if (finish)    state_next = DONE;
      DONE:    if (out_ready) state_next = IDLE;
      default:                state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (clear) state <= IDLE;
    else       state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      cnt      <= '0;
      tx       <= '0;
      rx       <= '0;
      out_data <= '0;
      mismatch <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          tx  <= in_data;
          rx  <= '0;
          cnt <= '0;
        end
        SHIFT: if (step) begin
          rx  <= rx_next;
          cnt <= cnt + CW'(1);
          // Result includes the bit captured on this final edge.
          if (finish) begin
            out_data <= rx_next;
            mismatch <= (rx_next != tx);
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign busy      = (state != IDLE);
  assign out_valid = (state == DONE);
  assign sr_load   = step;

endmodule

// File: tb/tb_siso_shift_ctrl.sv
// Directed bench for siso_shift_ctrl: an 8x8 instance driving a modelled SISO chain
// (with a stuck-at-0 tail option) and a 4x1 instance for back-to-back traffic.
module tb_siso_shift_ctrl;

  logic clk = 1'b0;
  logic clear;
  always #5 clk = ~clk;

  int total  = 0;
  int passed = 0;

  // Instance A: WIDTH=8, DEPTH=8
  logic       a_in_valid, a_in_ready, a_hold, a_sr_s_in, a_sr_load, a_sr_s_out;
  logic       a_out_valid, a_out_ready, a_mismatch, a_busy, a_fault;
  logic [7:0] a_in_data, a_out_data;
  logic [7:0] a_chain = 8'hA5;

  siso_shift_ctrl #(.WIDTH(8), .DEPTH(8)) dut_a (
    .clk(clk), .clear(clear), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .in_data(a_in_data), .hold(a_hold), .sr_s_in(a_sr_s_in), .sr_load(a_sr_load),
    .sr_s_out(a_sr_s_out), .out_valid(a_out_valid), .out_ready(a_out_ready),
    .out_data(a_out_data), .mismatch(a_mismatch), .busy(a_busy)
  );

  always @(posedge clk) if (a_sr_load) a_chain <= {a_chain[6:0], a_sr_s_in};
  assign a_sr_s_out = a_fault ? 1'b0 : a_chain[7];

  // Instance B: WIDTH=4, DEPTH=1
  logic       b_in_valid, b_in_ready, b_hold, b_sr_s_in, b_sr_load, b_sr_s_out;
  logic       b_out_valid, b_out_ready, b_mismatch, b_busy;
  logic [3:0] b_in_data, b_out_data;
  logic       b_chain = 1'b1;

  siso_shift_ctrl #(.WIDTH(4), .DEPTH(1)) dut_b (
    .clk(clk), .clear(clear), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_data(b_in_data), .hold(b_hold), .sr_s_in(b_sr_s_in), .sr_load(b_sr_load),
    .sr_s_out(b_sr_s_out), .out_valid(b_out_valid), .out_ready(b_out_ready),
    .out_data(b_out_data), .mismatch(b_mismatch), .busy(b_busy)
  );

  always @(posedge clk) if (b_sr_load) b_chain <= b_sr_s_in;
  assign b_sr_s_out = b_chain;

  // Accept a word on A and run until out_valid, holding during cycles hold_lo..hold_hi.
  // Returns the out_valid cycle (-1 on timeout) and the sr_s_in bits seen on load cycles.
  task automatic run_a(input logic [7:0] data, input int hold_lo, input int hold_hi,
                       output int ov_cycle, output int loads, output logic [15:0] seq,
                       output int hold_loads, output int hold_ones);
    a_in_data  = data;
    a_in_valid = 1'b1;
    @(posedge clk); #1;
    a_in_valid = 1'b0;
    ov_cycle = -1; loads = 0; seq = '0; hold_loads = 0; hold_ones = 0;
    for (int c = 1; c <= 40; c++) begin
      a_hold = (c >= hold_lo) && (c <= hold_hi);
      #1;
      if (a_out_valid) begin
        ov_cycle = c;
        break;
      end
      if (a_hold && a_sr_s_in) hold_ones++;
      if (a_sr_load) begin
        if (loads < 16) seq[loads] = a_sr_s_in;
        loads++;
        if (a_hold) hold_loads++;
      end
      @(posedge clk); #1;
    end
    a_hold = 1'b0;
  endtask

  task automatic ack_a();
    a_out_ready = 1'b1;
    @(posedge clk); #1;
    a_out_ready = 1'b0;
  endtask

  task automatic test_reset();
    clear = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    clear = 1'b0;
    total++; if (a_in_ready !== 1'b1)  $display("FAIL reset_in_ready got=%b exp=1", a_in_ready);   else passed++;
    total++; if (a_out_valid !== 1'b0) $display("FAIL reset_out_valid got=%b exp=0", a_out_valid); else passed++;
    total++; if (a_out_data !== 8'h00) $display("FAIL reset_out_data got=%h exp=00", a_out_data);  else passed++;
    total++; if (a_mismatch !== 1'b0)  $display("FAIL reset_mismatch got=%b exp=0", a_mismatch);   else passed++;
    total++; if (a_busy !== 1'b0)      $display("FAIL reset_busy got=%b exp=0", a_busy);           else passed++;
    total++; if (a_sr_load !== 1'b0)   $display("FAIL reset_sr_load got=%b exp=0", a_sr_load);     else passed++;
    total++; if (a_sr_s_in !== 1'b0)   $display("FAIL reset_sr_s_in got=%b exp=0", a_sr_s_in);     else passed++;
    total++; if (b_in_ready !== 1'b1)  $display("FAIL reset_b_in_ready got=%b exp=1", b_in_ready); else passed++;
  endtask

  task automatic test_basic();
    int ov, loads, hl, h1;
    logic [15:0] seq;
    run_a(8'hB2, 0, -1, ov, loads, seq, hl, h1);
    total++; if (ov !== 17)        $display("FAIL basic_ov_cycle got=%0d exp=17", ov);      else passed++;
    total++; if (loads !== 16)     $display("FAIL basic_loads got=%0d exp=16", loads);      else passed++;
    total++; if (seq !== 16'h00B2) $display("FAIL basic_sin_seq got=%h exp=00b2", seq);     else passed++;
    total++; if (a_out_data !== 8'hB2) $display("FAIL basic_data got=%h exp=b2", a_out_data); else passed++;
    total++; if (a_mismatch !== 1'b0)  $display("FAIL basic_mismatch got=%b exp=0", a_mismatch); else passed++;
    total++; if (a_busy !== 1'b1)      $display("FAIL basic_busy_done got=%b exp=1", a_busy);  else passed++;
    ack_a();
    total++; if (a_in_ready !== 1'b1)  $display("FAIL basic_in_ready_after got=%b exp=1", a_in_ready); else passed++;
    total++; if (a_busy !== 1'b0)      $display("FAIL basic_busy_after got=%b exp=0", a_busy);  else passed++;
  endtask

  task automatic test_hold();
    int ov, loads, hl, h1;
    logic [15:0] seq;
    run_a(8'hB2, 5, 7, ov, loads, seq, hl, h1);
    total++; if (ov !== 20)        $display("FAIL hold_ov_cycle got=%0d exp=20", ov);       else passed++;
    total++; if (hl !== 0)         $display("FAIL hold_sr_load got=%0d exp=0", hl);         else passed++;
    total++; if (h1 !== 3)         $display("FAIL hold_sin_frozen got=%0d exp=3", h1);      else passed++;
    total++; if (loads !== 16)     $display("FAIL hold_loads got=%0d exp=16", loads);       else passed++;
    total++; if (seq !== 16'h00B2) $display("FAIL hold_sin_seq got=%h exp=00b2", seq);      else passed++;
    total++; if (a_out_data !== 8'hB2) $display("FAIL hold_data got=%h exp=b2", a_out_data); else passed++;
    ack_a();
  endtask

  task automatic test_backpressure();
    int ov, loads, hl, h1;
    logic [15:0] seq;
    run_a(8'hC3, 0, -1, ov, loads, seq, hl, h1);
    total++; if (ov !== 17) $display("FAIL bp_ov_cycle got=%0d exp=17", ov); else passed++;
    a_in_data  = 8'h11;
    a_in_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      total++; if (a_out_valid !== 1'b1)  $display("FAIL bp_out_valid got=%b exp=1", a_out_valid); else passed++;
      total++; if (a_out_data !== 8'hC3)  $display("FAIL bp_data got=%h exp=c3", a_out_data);      else passed++;
      total++; if (a_mismatch !== 1'b0)   $display("FAIL bp_mismatch got=%b exp=0", a_mismatch);   else passed++;
      total++; if (a_in_ready !== 1'b0)   $display("FAIL bp_in_ready got=%b exp=0", a_in_ready);   else passed++;
      @(posedge clk); #1;
    end
    a_in_valid = 1'b0;
    ack_a();
    total++; if (a_in_ready !== 1'b1)  $display("FAIL bp_in_ready_after got=%b exp=1", a_in_ready); else passed++;
    total++; if (a_out_valid !== 1'b0) $display("FAIL bp_out_valid_after got=%b exp=0", a_out_valid); else passed++;
  endtask

  task automatic test_fault();
    int ov, loads, hl, h1;
    logic [15:0] seq;
    a_fault = 1'b1;
    run_a(8'hFF, 0, -1, ov, loads, seq, hl, h1);
    total++; if (ov !== 17)            $display("FAIL fault_ov_cycle got=%0d exp=17", ov);      else passed++;
    total++; if (a_out_data !== 8'h00) $display("FAIL fault_data got=%h exp=00", a_out_data);   else passed++;
    total++; if (a_mismatch !== 1'b1)  $display("FAIL fault_mismatch got=%b exp=1", a_mismatch); else passed++;
    ack_a();
    a_fault = 1'b0;
    run_a(8'h5A, 0, -1, ov, loads, seq, hl, h1);
    total++; if (ov !== 17)            $display("FAIL norm_ov_cycle got=%0d exp=17", ov);       else passed++;
    total++; if (a_out_data !== 8'h5A) $display("FAIL norm_data got=%h exp=5a", a_out_data);    else passed++;
    total++; if (a_mismatch !== 1'b0)  $display("FAIL norm_mismatch got=%b exp=0", a_mismatch); else passed++;
    ack_a();
  endtask

  task automatic test_clear_mid();
    int ov, loads, hl, h1, seen;
    logic [15:0] seq;
    a_in_data  = 8'h77;
    a_in_valid = 1'b1;
    @(posedge clk); #1;
    a_in_valid = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    total++; if (a_sr_load !== 1'b1) $display("FAIL clr_in_shift got=%b exp=1", a_sr_load); else passed++;
    clear  = 1'b1;
    a_hold = 1'b1;
    @(posedge clk); #1;
    clear  = 1'b0;
    a_hold = 1'b0;
    total++; if (a_in_ready !== 1'b1)  $display("FAIL clr_in_ready got=%b exp=1", a_in_ready); else passed++;
    total++; if (a_busy !== 1'b0)      $display("FAIL clr_busy got=%b exp=0", a_busy);         else passed++;
    total++; if (a_sr_load !== 1'b0)   $display("FAIL clr_sr_load got=%b exp=0", a_sr_load);   else passed++;
    total++; if (a_sr_s_in !== 1'b0)   $display("FAIL clr_sr_s_in got=%b exp=0", a_sr_s_in);   else passed++;
    total++; if (a_out_data !== 8'h00) $display("FAIL clr_out_data got=%h exp=00", a_out_data); else passed++;
    seen = 0;
    for (int c = 0; c < 30; c++) begin
      if (a_out_valid) seen++;
      @(posedge clk); #1;
    end
    total++; if (seen !== 0) $display("FAIL clr_no_out_valid got=%0d exp=0", seen); else passed++;
    run_a(8'h3C, 0, -1, ov, loads, seq, hl, h1);
    total++; if (ov !== 17)            $display("FAIL clr_new_ov got=%0d exp=17", ov);          else passed++;
    total++; if (a_out_data !== 8'h3C) $display("FAIL clr_new_data got=%h exp=3c", a_out_data); else passed++;
    total++; if (a_mismatch !== 1'b0)  $display("FAIL clr_new_mismatch got=%b exp=0", a_mismatch); else passed++;
    ack_a();
  endtask

  task automatic test_back_to_back();
    int acc[2];
    int hs[2];
    logic [3:0] od[2];
    logic       mm[2];
    int n_acc = 0;
    int n_hs  = 0;
    acc = '{-1, -1}; hs = '{-1, -1}; od = '{4'hx, 4'hx}; mm = '{1'bx, 1'bx};
    b_in_data   = 4'h9;
    b_in_valid  = 1'b1;
    b_out_ready = 1'b1;
    for (int c = 0; c < 30; c++) begin
      #1;
      if (b_in_ready && b_in_valid && n_acc < 2) begin
        acc[n_acc] = c;
        n_acc++;
      end
      if (b_out_valid && n_hs < 2) begin
        hs[n_hs] = c; od[n_hs] = b_out_data; mm[n_hs] = b_mismatch;
        n_hs++;
      end
      @(posedge clk); #1;
      if (n_acc == 1) b_in_data  = 4'h6;
      if (n_acc == 2) b_in_valid = 1'b0;
    end
    b_out_ready = 1'b0;
    total++; if (acc[0] !== 0)  $display("FAIL b2b_accept0 got=%0d exp=0", acc[0]);  else passed++;
    total++; if (hs[0] !== 6)   $display("FAIL b2b_hs0 got=%0d exp=6", hs[0]);       else passed++;
    total++; if (acc[1] !== 7)  $display("FAIL b2b_accept1 got=%0d exp=7", acc[1]);  else passed++;
    total++; if (hs[1] !== 13)  $display("FAIL b2b_hs1 got=%0d exp=13", hs[1]);     else passed++;
    total++; if (od[0] !== 4'h9) $display("FAIL b2b_data0 got=%h exp=9", od[0]);    else passed++;
    total++; if (od[1] !== 4'h6) $display("FAIL b2b_data1 got=%h exp=6", od[1]);    else passed++;
    total++; if (mm[0] !== 1'b0) $display("FAIL b2b_mm0 got=%b exp=0", mm[0]);      else passed++;
    total++; if (mm[1] !== 1'b0) $display("FAIL b2b_mm1 got=%b exp=0", mm[1]);      else passed++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    clear = 1'b1;
    a_in_valid = 1'b0; a_in_data = '0; a_hold = 1'b0; a_out_ready = 1'b0; a_fault = 1'b0;
    b_in_valid = 1'b0; b_in_data = '0; b_hold = 1'b0; b_out_ready = 1'b0;
    test_reset();
    test_basic();
    test_hold();
    test_backpressure();
    test_fault();
    test_clear_mid();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
